// File: rtl/seven_seg_scan_decoder.sv
// Sniffs a multiplexed active-low 8-digit seven-segment bus and recovers the hex
// value and decimal point shown on each digit once its pattern has settled.
module seven_seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic [7:0]  AN,
    input  logic        CA,
    input  logic        CB,
    input  logic        CC,
    input  logic        CD,
    input  logic        CE,
    input  logic        CF,
    input  logic        CG,
    input  logic        DP,
    output logic [31:0] digits,
    output logic [7:0]  dp_out,
    output logic [7:0]  digit_valid,
    output logic        bad_pattern,
    output logic        multi_an_err,
    output logic        frame_done
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(SETTLE_CYCLES - 1);

    logic [15:0]   raw_s;
    logic [15:0]   sync1_r;
    logic [15:0]   sync2_r;
    logic [15:0]   prev_r;
    logic [CW-1:0] stable_cnt_r;
    logic [7:0]    seen_r;
    logic [7:0]    seen_next_s;
    logic [7:0]    seen_base_s;
    logic          capture_s;
    logic          cap_one_s;
    logic          cap_multi_s;
    logic [7:0]    an_s;
    logic          dp_s;
    logic [4:0]    dec_s;
    logic [3:0]    lows_s;
    logic [2:0]    idx_s;

    // Returns {legal, value} for an active-high segment pattern (bit0 = a).
    function automatic logic [4:0] hex_decode(input logic [6:0] p);
        case (p)
            7'h3F:   hex_decode = {1'b1, 4'h0};
            7'h06:   hex_decode = {1'b1, 4'h1};
            7'h5B:   hex_decode = {1'b1, 4'h2};
            7'h4F:   hex_decode = {1'b1, 4'h3};
            7'h66:   hex_decode = {1'b1, 4'h4};
            7'h6D:   hex_decode = {1'b1, 4'h5};
            7'h7D:   hex_decode = {1'b1, 4'h6};
            7'h07:   hex_decode = {1'b1, 4'h7};
            7'h7F:   hex_decode = {1'b1, 4'h8};
            7'h6F:   hex_decode = {1'b1, 4'h9};
            7'h77:   hex_decode = {1'b1, 4'hA};
            7'h7C:   hex_decode = {1'b1, 4'hB};
            7'h39:   hex_decode = {1'b1, 4'hC};
            7'h5E:   hex_decode = {1'b1, 4'hD};
            7'h79:   hex_decode = {1'b1, 4'hE};
            7'h71:   hex_decode = {1'b1, 4'hF};
            default: hex_decode = 5'b0_0000;
        endcase
    endfunction

    function automatic logic [3:0] low_count(input logic [7:0] an);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, ~an[i]};
        end
        return n;
    endfunction

    function automatic logic [2:0] low_index(input logic [7:0] an);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!an[i]) begin
                k = 3'(i);
            end else begin
                k = k;
            end
        end
        return k;
    endfunction

    // Vector layout {AN, DP, CG..CA} keeps segment a at bit 0.
    assign raw_s       = {AN, DP, CG, CF, CE, CD, CC, CB, CA};
    assign an_s        = sync2_r[15:8];
    assign dp_s        = sync2_r[7];
    assign dec_s       = hex_decode(~sync2_r[6:0]);
    assign lows_s      = low_count(an_s);
    assign idx_s       = low_index(an_s);
    assign capture_s   = (sync2_r == prev_r) && (stable_cnt_r == CNT_PRE);
    assign cap_one_s   = capture_s && (lows_s == 4'd1);
    assign cap_multi_s = capture_s && (lows_s >= 4'd2);

    // Frame bookkeeping: a full seen set clears, but a same-cycle capture re-marks its digit.
    always_comb begin
        seen_base_s = seen_r;
        seen_next_s = seen_r;
        if (seen_r == 8'hFF) begin
            seen_base_s = 8'h00;
        end else begin
            seen_base_s = seen_r;
        end
        if (cap_one_s) begin
            seen_next_s = seen_base_s | (8'h01 << idx_s);
        end else begin
            seen_next_s = seen_base_s;
        end
    end

    // Input synchronizer and stability counter.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            sync1_r      <= 16'hFFFF;
            sync2_r      <= 16'hFFFF;
            prev_r       <= 16'hFFFF;
            stable_cnt_r <= '0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (sync2_r != prev_r) begin
                stable_cnt_r <= '0;
            end else if (stable_cnt_r != CNT_MAX) begin
                stable_cnt_r <= stable_cnt_r + CW'(1);
            end else begin
                stable_cnt_r <= stable_cnt_r;
            end
        end
    end

    // Per-digit capture and error pulses.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            digits       <= 32'h0000_0000;
            dp_out       <= 8'h00;
            digit_valid  <= 8'h00;
            bad_pattern  <= 1'b0;
            multi_an_err <= 1'b0;
        end else begin
            bad_pattern  <= 1'b0;
            multi_an_err <= 1'b0;
            if (cap_one_s) begin
                if (dec_s[4]) begin
                    digits[{idx_s, 2'b00} +: 4] <= dec_s[3:0];
                    dp_out[idx_s]               <= ~dp_s;
                    digit_valid[idx_s]          <= 1'b1;
                end else begin
                    digit_valid[idx_s] <= 1'b0;
                    bad_pattern        <= 1'b1;
                end
            end else if (cap_multi_s) begin
                multi_an_err <= 1'b1;
            end else begin
                multi_an_err <= 1'b0;
            end
        end
    end

    // Frame completion tracking.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            seen_r     <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            seen_r     <= seen_next_s;
            frame_done <= (seen_r == 8'hFF);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Randomized and directed bench for seven_seg_scan_decoder, checked every cycle
// against a window-based reference model of the settle/capture rules.
module tb_seven_seg_scan_decoder;

    localparam int S = 16;
    localparam int MAXC = 20000;
    localparam logic [15:0] ONES = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] vec = ONES;
    logic [7:0]  an;
    logic        ca, cb, cc, cd, ce, cf, cg, dp;
    logic [31:0] digits;
    logic [7:0]  dp_out;
    logic [7:0]  digit_valid;
    logic        bad_pattern;
    logic        multi_an_err;
    logic        frame_done;

    assign an = vec[15:8];
    assign dp = vec[7];
    assign cg = vec[6];
    assign cf = vec[5];
    assign ce = vec[4];
    assign cd = vec[3];
    assign cc = vec[2];
    assign cb = vec[1];
    assign ca = vec[0];

    seven_seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
        .CLK100MHZ(clk), .rst(rst), .AN(an),
        .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf), .CG(cg), .DP(dp),
        .digits(digits), .dp_out(dp_out), .digit_valid(digit_valid),
        .bad_pattern(bad_pattern), .multi_an_err(multi_an_err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rst = 0;
    logic [15:0] hist [0:MAXC-1];
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [3:0] m_dig [8];
    bit         m_dp [8];
    bit         m_val [8];
    bit         m_seen [8];
    bit         m_fpend;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Synchronized vector seen at edge i; anything up to the last reset reads as idle.
    function automatic logic [15:0] hv(input int i);
        if (i < 1 || i <= last_rst) return ONES;
        return hist[i];
    endfunction

    // A capture lands at edge c when edges c-2-S..c-2 carried one vector that began a new run.
    function automatic bit is_capture(input int c);
        logic [15:0] v;
        v = hv(c - 2);
        for (int j = 1; j <= S; j++) begin
            if (hv(c - 2 - j) != v) return 1'b0;
        end
        return hv(c - 3 - S) != v;
    endfunction

    function automatic logic [15:0] mk(input logic [7:0] a, input int val, input bit dp_on);
        logic [6:0] p;
        p = hex_tab[val];
        return {a, ~dp_on, ~p};
    endfunction

    function automatic logic [15:0] mkp(input logic [7:0] a, input logic [6:0] p, input bit dp_on);
        return {a, ~dp_on, ~p};
    endfunction

    task automatic hold(input logic [15:0] v, input int n);
        vec = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model and per-cycle comparison.
    initial begin : monitor
        logic [15:0] v;
        logic [31:0] e_dig;
        logic [7:0]  e_dp, e_val;
        bit          e_fd, e_bad, e_multi, found, all_seen;
        int          lows, k, val;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc >= MAXC) begin
                $display("FAIL cycle_budget: got %0d cycles expected below %0d", cyc, MAXC);
                $fatal(1, "cycle budget exhausted");
            end
            hist[cyc] = rst ? ONES : vec;
            @(negedge clk);
            e_fd = 1'b0; e_bad = 1'b0; e_multi = 1'b0;
            if (rst) begin
                last_rst = cyc;
                m_fpend = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    m_dig[i] = 4'h0; m_dp[i] = 1'b0; m_val[i] = 1'b0; m_seen[i] = 1'b0;
                end
            end else begin
                if (m_fpend) begin
                    e_fd = 1'b1;
                    m_fpend = 1'b0;
                    for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
                end
                if (is_capture(cyc)) begin
                    v = hv(cyc - 2);
                    lows = 0; k = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (!v[8 + i]) begin
                            lows++;
                            k = i;
                        end
                    end
                    if (lows == 1) begin
                        found = 1'b0; val = 0;
                        for (int h = 0; h < 16; h++) begin
                            if (hex_tab[h] == ~v[6:0]) begin
                                found = 1'b1;
                                val = h;
                            end
                        end
                        if (found) begin
                            m_dig[k] = 4'(val);
                            m_dp[k]  = ~v[7];
                            m_val[k] = 1'b1;
                        end else begin
                            m_val[k] = 1'b0;
                            e_bad = 1'b1;
                        end
                        m_seen[k] = 1'b1;
                    end else if (lows >= 2) begin
                        e_multi = 1'b1;
                    end
                    all_seen = 1'b1;
                    for (int i = 0; i < 8; i++) all_seen = all_seen & m_seen[i];
                    if (all_seen) m_fpend = 1'b1;
                end
            end
            for (int i = 0; i < 8; i++) begin
                e_dig[4*i +: 4] = m_dig[i];
                e_dp[i]  = m_dp[i];
                e_val[i] = m_val[i];
            end
            check_eq("digits", digits, e_dig);
            check_eq("dp_out", {24'h0, dp_out}, {24'h0, e_dp});
            check_eq("digit_valid", {24'h0, digit_valid}, {24'h0, e_val});
            check_eq("bad_pattern", {31'h0, bad_pattern}, {31'h0, e_bad});
            check_eq("multi_an_err", {31'h0, multi_an_err}, {31'h0, e_multi});
            check_eq("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
        end
    end

    // Stimulus: directed scenarios followed by random scan phases.
    initial begin : stim
        logic [7:0] a;
        logic [6:0] p;
        int r;
        rst = 1'b1;
        vec = ONES;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        hold(mk(8'hFE, 3, 1'b0), 20);
        check_eq("first_digit", {28'h0, digits[3:0]}, 32'h3);
        check_eq("first_valid", {24'h0, digit_valid}, 32'h01);
        check_eq("first_dp", {24'h0, dp_out}, 32'h00);

        for (int k = 0; k < 8; k++) begin
            a = ~(8'h01 << k);
            hold(mk(a, k, k == 5), 20);
        end
        check_eq("scan_digits", digits, 32'h7654_3210);
        check_eq("scan_dp", {24'h0, dp_out}, 32'h20);
        check_eq("scan_valid", {24'h0, digit_valid}, 32'hFF);

        hold(mk(8'hFD, 9, 1'b0), S - 1);
        hold(mk(8'hFD, 10, 1'b0), S + 2);
        hold(mk(8'hFD, 10, 1'b0), 40);
        hold(mk(8'hFB, 5, 1'b0), 10);
        hold(mk(8'hFB, 6, 1'b0), 1);
        hold(mk(8'hFB, 5, 1'b0), S + 3);

        hold(mk(8'hFE, 3, 1'b0), 20);
        hold(mkp(8'hFE, 7'h00, 1'b0), 20);
        check_eq("bad_keeps_digit", {28'h0, digits[3:0]}, 32'h3);
        check_eq("bad_clears_valid", {31'h0, digit_valid[0]}, 32'h0);
        hold(mk(8'hFC, 1, 1'b0), 20);
        hold(mk(8'hFF, 8, 1'b1), 20);

        for (int k = 0; k < 4; k++) begin
            a = ~(8'h01 << k);
            hold(mk(a, k + 8, 1'b0), 20);
        end
        rst = 1'b1;
        #1;
        check_eq("async_rst_digits", digits, 32'h0);
        check_eq("async_rst_valid", {24'h0, digit_valid}, 32'h0);
        check_eq("async_rst_dp", {24'h0, dp_out}, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a = ~(8'h01 << k);
            hold(mk(a, 15 - k, k[0]), 20);
        end
        check_eq("rescan_digits", digits, 32'h89AB_CDEF);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) a = ~(8'h01 << $urandom_range(0, 7));
            else if (r == 7) a = 8'hFF;
            else a = 8'($urandom);
            if ($urandom_range(0, 4) != 0) p = hex_tab[$urandom_range(0, 15)];
            else p = 7'($urandom);
            hold(mkp(a, p, 1'($urandom)), $urandom_range(1, S + 6));
        end
        hold(ONES, S + 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receive-side counterpart of the board's seven-segment display path. The block watches the multiplexed, active-low anode/segment/DP lines that drive the 8-digit display and recovers the hex value shown on each digit. Each digit's segment pattern is captured only after it has been stable for a programmable number of cycles. The block sits beside the display driver as a self-check/loopback monitor, or in front of an external display bus being sniffed.

## Interface
Parameters:
- SETTLE_CYCLES, 16, number of consecutive identical synchronized samples required before a capture; legal range 2..255.

Ports:
- CLK100MHZ  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- AN  in  8  digit anodes, active-low; AN[k]=0 selects digit k.
- CA, CB, CC, CD, CE, CF, CG  in  1 each  segment lines a..g, active-low.
- DP  in  1  decimal point, active-low.
- digits  out  32  recovered hex values; digit k at [4k+3:4k].
- dp_out  out  8  recovered decimal point per digit, active-high.
- digit_valid  out  8  digit k holds a legal decoded value.
- bad_pattern  out  1  one-cycle pulse: a capture saw a non-hex segment pattern.
- multi_an_err  out  1  one-cycle pulse: a capture saw more than one anode low.
- frame_done  out  1  one-cycle pulse: all 8 digits captured since the previous pulse.

## Operation
- Input stage: 2-flop synchronizer on all 16 inputs (AN, CA..CG, DP). Synchronizer reset value is all ones (inactive).
- Stability filter:
  - prev register holds the last synchronized 16-bit vector.
  - stable_cnt clears to 0 whenever the synchronized vector differs from prev.
  - Otherwise stable_cnt increments, saturating at SETTLE_CYCLES.
  - Counter width is $clog2(SETTLE_CYCLES+1).
- Capture event: fires exactly once per stable period, on the cycle stable_cnt steps from SETTLE_CYCLES-1 to SETTLE_CYCLES. No re-capture while saturated.
- At capture, with pattern p = ~{CG,CF,CE,CD,CC,CB,CA} (bit0 = a):
  - AN all ones (blanking): no update, no flag.
  - Exactly one AN bit k low, p in hex table: digits[k] <= value; dp_out[k] <= ~DP; digit_valid[k] <= 1; seen[k] <= 1.
  - Exactly one AN bit k low, p not in table: digits[k] and dp_out[k] unchanged; digit_valid[k] <= 0; seen[k] <= 1; bad_pattern pulses.
  - Two or more AN bits low: no update; multi_an_err pulses.
- Hex table (p, in hex, for values 0..F): 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71. All other patterns are illegal, including 00.
- Frame tracking:
  - seen is an 8-bit register.
  - On the cycle after seen becomes 8'hFF: frame_done = 1 and seen clears to 0.
  - A capture in that same cycle sets its seen bit after the clear. Set wins over clear for that bit.
- Recapture of an already-seen digit within a frame overwrites its value. It does not advance frame_done.

## Timing
- Reset values:
  - digits = 0, dp_out = 0, digit_valid = 0.
  - bad_pattern = multi_an_err = frame_done = 0.
  - seen = 0, stable_cnt = 0, prev = all ones.
- Reset is asynchronous assert, synchronous deassert (by the system). Reset mid-frame discards all partial captures.
- Latency: input held constant from rising edge E (first edge sampling it) → digits/dp_out/digit_valid/flags update at edge E + SETTLE_CYCLES + 2.
- frame_done asserts 1 cycle after the capture that completes the frame.
- An input change at any point before capture restarts the count. Any glitch of at least 1 cycle at the synchronizer output resets stable_cnt.
- Inputs are asynchronous to CLK100MHZ. Multi-bit skew settles within the filter because SETTLE_CYCLES ≥ 2.
- bad_pattern and multi_an_err can never coincide, since each capture has a single classification.

## Test plan
- Reset, then hold AN=8'hFE, segments encoding 3 (p=4F), DP high for 20 cycles (SETTLE_CYCLES=16) → digits[3:0]=3, digit_valid=8'h01, dp_out=0, update at edge E+18, no flags.
- Scan digits 0..7 showing 0,1,…,7 for 20 cycles each, DP low on digit 5 → digits=32'h76543210, dp_out=8'h20, digit_valid=8'hFF, one frame_done pulse one cycle after digit 7 capture.
- Hold a pattern for only SETTLE_CYCLES-1 cycles, then change → no capture; a hold of exactly SETTLE_CYCLES+2 → one capture, and continued holding produces no second capture.
- AN=8'hFE with p=00 after a valid 3 was shown → bad_pattern pulse, digit_valid[0]=0, digits[3:0] still 3; AN=8'hFC stable → multi_an_err pulse, no change; AN=8'hFF → nothing.
- Assert rst mid-scan after digits 0..3 captured → all outputs 0 immediately; rescanning all 8 digits yields frame_done only after the 8th post-reset capture.
